dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
//  Shares the single-port data memory between the pipeline MEM stage (EX/MEM MemRead/MemWrite/addr/wdata)
//  and an external requester (testbench loader / DMA). Drives a ready/valid memory interface and raises
//  cpu_stall to freeze the whole pipeline while a CPU access is pending or waiting on the other master.
//  CPU has priority; a starvation counter guarantees the external port a grant.
// PARAMETERS
//  DATA_WIDTH    32  data bus width
//  ADDR_WIDTH    32  byte address width
//  EXT_MAX_WAIT  4   consecutive contended CPU grants before the external port is forced a grant (>=1)
// PORTS
//  clk         in   1           clock; all state updates on rising edge
//  rst         in   1           synchronous, active-high reset
//  cpu_mem_read  in 1           MemRead from EX/MEM register
//  cpu_mem_write in 1           MemWrite from EX/MEM register
//  cpu_addr    in   ADDR_WIDTH  ALU result from EX/MEM register
//  cpu_wdata   in   DATA_WIDTH  store data from EX/MEM register
//  cpu_rdata   out  DATA_WIDTH  load data to MEM/WB register
//  cpu_stall   out  1           freeze all pipeline stages this cycle
//  ext_req     in   1           external request; level, held until ext_ack
//  ext_we      in   1           1 = write, 0 = read
//  ext_addr    in   ADDR_WIDTH  external address
//  ext_wdata   in   DATA_WIDTH  external write data
//  ext_ack     out  1           one-cycle completion pulse
//  ext_rdata   out  DATA_WIDTH  external read data, valid when ext_ack=1
//  mem_en      out  1           memory request; held until mem_ready
//  mem_we      out  1           memory write enable
//  mem_addr    out  ADDR_WIDTH  memory address
//  mem_wdata   out  DATA_WIDTH  memory write data
//  mem_rdata   in   DATA_WIDTH  memory read data, valid when mem_ready=1
//  mem_ready   in   1           access completes this cycle (may be high in the first mem_en cycle)
// BEHAVIOUR
//  cpu_req = cpu_mem_read | cpu_mem_write; if both are high, the access is a write.
//  FSM states: IDLE, CPU_BUSY, EXT_BUSY; state, mem_*, and starve_cnt are registered.
//  Arbitration decision is made in IDLE only. Registered mem_* fields are loaded on entry to BUSY
//  and stay constant until completion.
//  - IDLE: if cpu_req and not (ext_req and starve_cnt==EXT_MAX_WAIT), go to CPU_BUSY.
//    Else if ext_req, go to EXT_BUSY. Else stay in IDLE.
//  - CPU_BUSY: mem_en=1, mem_we/addr/wdata latched from the cpu_* inputs.
//    On mem_ready: cpu_rdata=mem_rdata in that cycle, then go to IDLE.
//  - EXT_BUSY: mem_en=1, fields latched from ext_*. On mem_ready: ext_ack=1 and ext_rdata=mem_rdata
//    for that cycle, then go to IDLE.
//  Completion always returns to IDLE, giving one arbitration cycle per access.
//  Minimum CPU access latency is 2 cycles: the request cycle (IDLE) plus the access cycle with mem_ready=1.
//  cpu_stall (combinational) = cpu_req & ~(state==CPU_BUSY & mem_ready); forced to 0 while rst=1.
//  The pipeline advances on the edge that ends the completion cycle, so the same access is never re-granted.
//  starve_cnt:
//   - +1 on each IDLE->CPU_BUSY transition taken while ext_req=1 (saturates at EXT_MAX_WAIT).
//   - Cleared on IDLE->EXT_BUSY.
//   - Unchanged otherwise.
//  A CPU request arriving while in EXT_BUSY stalls until the external access completes, then re-arbitrates.
//  ext_req dropped before ext_ack is a protocol violation; the arbiter still completes the latched access.
//  Reset values: state=IDLE, starve_cnt=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, ext_ack=0.
//  Also cpu_rdata=0 and ext_rdata=0 outside completion cycles.
//  Reset mid-access: the next cycle is IDLE with mem_en=0; the in-flight access is abandoned and no ack is issued.
//  mem_rdata is ignored when mem_we=1; cpu_rdata/ext_rdata are 0 on write completions.
// TESTING
//  1. CPU load at 0x10, memory returns 0xDEADBEEF with zero wait:
//     cpu_stall=1 for 1 cycle; mem_en high for 1 cycle; cpu_rdata=0xDEADBEEF in the cpu_stall=0 cycle.
//  2. CPU store 0x20<-0x1234, mem_ready delayed 3 cycles:
//     mem_en/mem_we/addr/wdata stable for 4 cycles; cpu_stall=1 for 4 cycles; then 0.
//  3. ext_req read at 0x40 while idle: ext_ack pulses exactly once, 2 cycles after ext_req rises (zero-wait memory),
//     with ext_rdata = memory value.
//  4. ext_req held while the CPU issues back-to-back loads: with EXT_MAX_WAIT=4, the ext access is granted
//     after the 4th CPU access; the 5th CPU load stalls until ext_ack; starve_cnt returns to 0.
//  5. cpu_mem_read=cpu_mem_write=1: a write is issued (mem_we=1).
//     Simultaneous first-cycle cpu_req and ext_req with starve_cnt=0: the CPU is granted first.
//  6. Assert rst during CPU_BUSY with mem_ready=0: the next cycle shows mem_en=0, cpu_stall=0, ext_ack=0, state IDLE;
//     a fresh load then completes normally.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Single-port data memory arbiter between the pipeline MEM stage and an external requester.
// CPU has priority; a starvation counter forces an external grant after EXT_MAX_WAIT contended CPU grants.
module dmem_arbiter #(
   parameter int DATA_WIDTH   = 32,
   parameter int ADDR_WIDTH   = 32,
   parameter int EXT_MAX_WAIT = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cpu_mem_read,
   input  logic                  cpu_mem_write,
   input  logic [ADDR_WIDTH-1:0] cpu_addr,
   input  logic [DATA_WIDTH-1:0] cpu_wdata,
   output logic [DATA_WIDTH-1:0] cpu_rdata,
   output logic                  cpu_stall,
   input  logic                  ext_req,
   input  logic                  ext_we,
   input  logic [ADDR_WIDTH-1:0] ext_addr,
   input  logic [DATA_WIDTH-1:0] ext_wdata,
   output logic                  ext_ack,
   output logic [DATA_WIDTH-1:0] ext_rdata,
   output logic                  mem_en,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   input  logic                  mem_ready
);

   localparam int CNT_W = $clog2(EXT_MAX_WAIT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(EXT_MAX_WAIT);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      CPU_BUSY = 2'd1,
      EXT_BUSY = 2'd2
   } state_t;

   state_t                  state_q, state_d;
   logic [CNT_W-1:0]        starve_cnt_q, starve_cnt_d;
   logic                    mem_en_q, mem_en_d;
   logic                    mem_we_q, mem_we_d;
   logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
   logic [DATA_WIDTH-1:0]   mem_wdata_q, mem_wdata_d;

   logic                    cpu_req_s;
   logic                    ext_forced_s;
   logic                    cpu_done_s;
   logic                    ext_done_s;

   assign cpu_req_s    = cpu_mem_read | cpu_mem_write;
   assign ext_forced_s = ext_req & (starve_cnt_q == CNT_MAX);

   // Next-state: arbitration in IDLE, hold latched access fields until mem_ready
   always_comb begin
      state_d      = state_q;
      starve_cnt_d = starve_cnt_q;
      mem_en_d     = mem_en_q;
      mem_we_d     = mem_we_q;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      case (state_q)
         IDLE: begin
            if (cpu_req_s && !ext_forced_s) begin
               state_d     = CPU_BUSY;
               mem_en_d    = 1'b1;
               mem_we_d    = cpu_mem_write;
               mem_addr_d  = cpu_addr;
               mem_wdata_d = cpu_wdata;
               if (ext_req && (starve_cnt_q != CNT_MAX)) begin
                  starve_cnt_d = starve_cnt_q + CNT_W'(1);
               end else begin
                  starve_cnt_d = starve_cnt_q;
               end
            end else if (ext_req) begin
               state_d      = EXT_BUSY;
               mem_en_d     = 1'b1;
               mem_we_d     = ext_we;
               mem_addr_d   = ext_addr;
               mem_wdata_d  = ext_wdata;
               starve_cnt_d = '0;
            end else begin
               mem_en_d = 1'b0;
            end
         end
         CPU_BUSY, EXT_BUSY: begin
            if (mem_ready) begin
               state_d  = IDLE;
               mem_en_d = 1'b0;
            end else begin
               mem_en_d = 1'b1;
            end
         end
         default: begin
            state_d  = IDLE;
            mem_en_d = 1'b0;
         end
      endcase
   end

   // State and memory-request registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         starve_cnt_q <= '0;
         mem_en_q     <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
      end else begin
         state_q      <= state_d;
         starve_cnt_q <= starve_cnt_d;
         mem_en_q     <= mem_en_d;
         mem_we_q     <= mem_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
      end
   end

   // Completion-cycle responses; read data is returned only for reads and never during reset
   always_comb begin
      cpu_done_s = ~rst & (state_q == CPU_BUSY) & mem_ready;
      ext_done_s = ~rst & (state_q == EXT_BUSY) & mem_ready;
      cpu_stall  = ~rst & cpu_req_s & ~cpu_done_s;
      ext_ack    = ext_done_s;
      if (cpu_done_s && !mem_we_q) begin
         cpu_rdata = mem_rdata;
      end else begin
         cpu_rdata = '0;
      end
      if (ext_done_s && !mem_we_q) begin
         ext_rdata = mem_rdata;
      end else begin
         ext_rdata = '0;
      end
   end

   assign mem_en    = mem_en_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a wait-state memory model and read-data scoreboards.
module tb_dmem_arbiter;

   logic        clk;
   logic        rst;
   logic        cpu_mem_read, cpu_mem_write;
   logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
   logic        cpu_stall;
   logic        ext_req, ext_we;
   logic [31:0] ext_addr, ext_wdata, ext_rdata;
   logic        ext_ack;
   logic        mem_en, mem_we;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic        mem_ready;

   int n_assert = 0;
   int n_fail   = 0;
   int ack_cnt  = 0;
   int wait_target;
   int wait_cnt;

   logic [31:0] store   [0:255];
   bit          written [0:255];

   logic [31:0] exp_cpu [$];
   logic [31:0] exp_ext [$];

   logic        s_stall, s_men, s_we, s_ack;
   logic [31:0] s_addr, s_wdata;

   dmem_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .EXT_MAX_WAIT(4)) dut (
      .clk(clk), .rst(rst),
      .cpu_mem_read(cpu_mem_read), .cpu_mem_write(cpu_mem_write),
      .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
      .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
      .ext_ack(ext_ack), .ext_rdata(ext_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ready(mem_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] pat(input logic [31:0] a);
      if (a == 32'h0000_0010) return 32'hDEAD_BEEF;
      return {~a[15:0], a[15:0]} ^ 32'h0F0F_0000;
   endfunction

   // Memory model: completes after wait_target extra cycles, stores writes
   always @(posedge clk) begin
      if (rst) begin
         wait_cnt <= 0;
      end else if (mem_en && mem_ready) begin
         wait_cnt <= 0;
         if (mem_we) begin
            store[mem_addr[9:2]]   <= mem_wdata;
            written[mem_addr[9:2]] <= 1'b1;
         end
      end else if (mem_en) begin
         wait_cnt <= wait_cnt + 1;
      end else begin
         wait_cnt <= 0;
      end
   end

   always_comb begin
      mem_ready = mem_en && (wait_cnt >= wait_target);
      mem_rdata = written[mem_addr[9:2]] ? store[mem_addr[9:2]] : pat(mem_addr);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // One clock: sample on the falling edge, score completions, return just after the next rising edge
   task automatic tick();
      logic cpu_done;
      @(negedge clk);
      s_stall = cpu_stall; s_men = mem_en; s_we = mem_we;
      s_addr  = mem_addr;  s_wdata = mem_wdata; s_ack = ext_ack;
      cpu_done = !rst && (cpu_mem_read || cpu_mem_write) && !cpu_stall;
      if (cpu_done) begin
         if (exp_cpu.size() == 0) check("cpu_sb_unexpected", 32'd1, 32'd0);
         else check("cpu_rdata", cpu_rdata, exp_cpu.pop_front());
      end else begin
         check("cpu_rdata_quiet", cpu_rdata, 32'd0);
      end
      if (ext_ack) begin
         ack_cnt++;
         if (exp_ext.size() == 0) check("ext_sb_unexpected", 32'd1, 32'd0);
         else check("ext_rdata", ext_rdata, exp_ext.pop_front());
      end else begin
         check("ext_rdata_quiet", ext_rdata, 32'd0);
      end
      @(posedge clk);
      #1;
      if (s_ack) ext_req = 1'b0;
   endtask

   task automatic wait_cpu_done(input logic exp_we, input logic [31:0] exp_addr,
                                input logic [31:0] exp_wdata,
                                output int stalls, output int men, output int bad);
      stalls = 0; men = 0; bad = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (s_men) begin
            men++;
            if (s_we !== exp_we || s_addr !== exp_addr || s_wdata !== exp_wdata) bad++;
         end
         if (s_stall) stalls++;
         else break;
      end
      cpu_mem_read  = 1'b0;
      cpu_mem_write = 1'b0;
   endtask

   initial begin
      int st, mn, bd, acks0, n;
      rst = 1'b1; cpu_mem_read = 1'b0; cpu_mem_write = 1'b0;
      cpu_addr = 32'd0; cpu_wdata = 32'd0;
      ext_req = 1'b0; ext_we = 1'b0; ext_addr = 32'd0; ext_wdata = 32'd0;
      wait_target = 0;
      tick(); tick();
      check("rst_stall", 32'(s_stall), 32'd0);
      check("rst_ack", 32'(s_ack), 32'd0);
      rst = 1'b0;
      tick();
      check("reset_mem_en", 32'(s_men), 32'd0);
      check("reset_mem_we", 32'(s_we), 32'd0);
      check("reset_mem_addr", s_addr, 32'd0);
      check("reset_mem_wdata", s_wdata, 32'd0);
      check("reset_starve", 32'(dut.starve_cnt_q), 32'd0);

      // 1: zero-wait load
      cpu_mem_read = 1'b1; cpu_addr = 32'h10; exp_cpu.push_back(32'hDEAD_BEEF);
      wait_cpu_done(1'b0, 32'h10, 32'd0, st, mn, bd);
      check("t1_stall_cycles", 32'(st), 32'd1);
      check("t1_mem_en_cycles", 32'(mn), 32'd1);
      check("t1_fields", 32'(bd), 32'd0);

      // 2: store with 3 wait states, then read it back
      wait_target = 3;
      cpu_mem_write = 1'b1; cpu_addr = 32'h20; cpu_wdata = 32'h1234; exp_cpu.push_back(32'd0);
      wait_cpu_done(1'b1, 32'h20, 32'h1234, st, mn, bd);
      check("t2_stall_cycles", 32'(st), 32'd4);
      check("t2_mem_en_cycles", 32'(mn), 32'd4);
      check("t2_fields_stable", 32'(bd), 32'd0);
      tick();
      check("t2_stall_after", 32'(s_stall), 32'd0);
      wait_target = 0;
      cpu_mem_read = 1'b1; cpu_addr = 32'h20; cpu_wdata = 32'd0; exp_cpu.push_back(32'h1234);
      wait_cpu_done(1'b0, 32'h20, 32'd0, st, mn, bd);
      check("t2_readback_stall", 32'(st), 32'd1);

      // 3: external read while idle
      ext_req = 1'b1; ext_we = 1'b0; ext_addr = 32'h40; exp_ext.push_back(pat(32'h40));
      tick(); check("t3_ack_c0", 32'(s_ack), 32'd0);
      tick(); check("t3_ack_c1", 32'(s_ack), 32'd1);
      tick(); check("t3_ack_c2", 32'(s_ack), 32'd0);
      check("t3_ack_count", 32'(ack_cnt), 32'd1);

      // 4: starvation limit with back-to-back loads
      ext_req = 1'b1; ext_addr = 32'h80; exp_ext.push_back(pat(32'h80));
      acks0 = ack_cnt;
      for (int k = 0; k < 4; k++) begin
         cpu_mem_read = 1'b1; cpu_addr = 32'h100 + 32'(4 * k);
         exp_cpu.push_back(pat(32'h100 + 32'(4 * k)));
         wait_cpu_done(1'b0, 32'h100 + 32'(4 * k), 32'd0, st, mn, bd);
         check("t4_cpu_grant_stall", 32'(st), 32'd1);
      end
      check("t4_starve_max", 32'(dut.starve_cnt_q), 32'd4);
      check("t4_no_ack_yet", 32'(ack_cnt), 32'(acks0));
      cpu_mem_read = 1'b1; cpu_addr = 32'h110; exp_cpu.push_back(pat(32'h110));
      wait_cpu_done(1'b0, 32'h110, 32'd0, st, mn, bd);
      check("t4_fifth_stall", 32'(st), 32'd3);
      check("t4_ext_acked", 32'(ack_cnt), 32'(acks0 + 1));
      check("t4_starve_clear", 32'(dut.starve_cnt_q), 32'd0);

      // 5a: read and write both high issue a write
      cpu_mem_read = 1'b1; cpu_mem_write = 1'b1; cpu_addr = 32'h30; cpu_wdata = 32'h55AA;
      exp_cpu.push_back(32'd0);
      wait_cpu_done(1'b1, 32'h30, 32'h55AA, st, mn, bd);
      check("t5_write_fields", 32'(bd), 32'd0);
      check("t5_write_mem_en", 32'(mn), 32'd1);

      // 5b: simultaneous requests with starve_cnt=0, CPU goes first
      ext_req = 1'b1; ext_addr = 32'h44; exp_ext.push_back(pat(32'h44));
      cpu_mem_read = 1'b1; cpu_addr = 32'h14; exp_cpu.push_back(pat(32'h14));
      wait_cpu_done(1'b0, 32'h14, 32'd0, st, mn, bd);
      check("t5_cpu_first", 32'(st), 32'd1);
      check("t5_starve_one", 32'(dut.starve_cnt_q), 32'd1);
      n = 0;
      for (int i = 0; i < 20; i++) begin
         tick(); n++;
         if (s_ack) break;
      end
      check("t5_ext_ack_delay", 32'(n), 32'd2);
      check("t5_starve_zero", 32'(dut.starve_cnt_q), 32'd0);

      // 6: reset in the middle of a CPU access
      wait_target = 5;
      cpu_mem_read = 1'b1; cpu_addr = 32'h18;
      tick(); tick();
      check("t6_busy_mem_en", 32'(s_men), 32'd1);
      rst = 1'b1; cpu_mem_read = 1'b0;
      tick();
      check("t6_rst_stall", 32'(s_stall), 32'd0);
      check("t6_rst_ack", 32'(s_ack), 32'd0);
      rst = 1'b0;
      tick();
      check("t6_mem_en", 32'(s_men), 32'd0);
      check("t6_stall", 32'(s_stall), 32'd0);
      check("t6_ack", 32'(s_ack), 32'd0);
      check("t6_state_idle", 32'(dut.state_q), 32'd0);
      wait_target = 0;
      cpu_mem_read = 1'b1; cpu_addr = 32'h10; exp_cpu.push_back(32'hDEAD_BEEF);
      wait_cpu_done(1'b0, 32'h10, 32'd0, st, mn, bd);
      check("t6_fresh_load", 32'(st), 32'd1);

      tick();
      check("sb_cpu_drained", 32'(exp_cpu.size()), 32'd0);
      check("sb_ext_drained", 32'(exp_ext.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
